// File: rtl/cache_axi_arbiter.sv
// Arbitrates icache/dcache line reads onto one bridge read channel and
// holds a single-entry dcache victim write buffer on the bridge write channel.
module cache_axi_arbiter #(
    parameter bit DC_PRIO = 1'b0
) (
    input  logic         clk_g,
    input  logic         resetn,
    input  logic         ic_rd_req,
    input  logic [2:0]   ic_rd_type,
    input  logic [31:0]  ic_rd_addr,
    output logic         ic_rd_rdy,
    output logic         ic_ret_valid,
    output logic         ic_ret_last,
    input  logic         dc_rd_req,
    input  logic [2:0]   dc_rd_type,
    input  logic [31:0]  dc_rd_addr,
    output logic         dc_rd_rdy,
    output logic         dc_ret_valid,
    output logic         dc_ret_last,
    output logic [31:0]  ret_data,
    input  logic         dc_wr_req,
    input  logic [2:0]   dc_wr_type,
    input  logic [31:0]  dc_wr_addr,
    input  logic [3:0]   dc_wr_wstrb,
    input  logic [127:0] dc_wr_data,
    output logic         dc_wr_rdy,
    output logic         mem_rd_req,
    output logic [2:0]   mem_rd_type,
    output logic [31:0]  mem_rd_addr,
    input  logic         mem_rd_rdy,
    input  logic         mem_ret_valid,
    input  logic         mem_ret_last,
    input  logic [31:0]  mem_ret_data,
    output logic         mem_wr_req,
    output logic [2:0]   mem_wr_type,
    output logic [31:0]  mem_wr_addr,
    output logic [3:0]   mem_wr_wstrb,
    output logic [127:0] mem_wr_data,
    input  logic         mem_wr_rdy,
    input  logic         mem_wr_done
);

    typedef enum logic [1:0] {R_IDLE, R_REQ, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_EMPTY, W_PEND, W_WAIT} wr_state_t;

    rd_state_t r_state, r_next;
    wr_state_t w_state, w_next;

    logic         owner_dc;
    logic         last_dc;
    logic [2:0]   rd_type_q;
    logic [31:0]  rd_addr_q;
    logic [2:0]   wr_type_q;
    logic [31:0]  wr_addr_q;
    logic [3:0]   wr_wstrb_q;
    logic [127:0] wr_data_q;

    logic hazard, dc_elig, grant, grant_dc, wr_load;

    // A dcache read of the line sitting in the write buffer must wait until
    // the write has completed, otherwise it would fetch stale memory.
    assign hazard  = (w_state != W_EMPTY) && (dc_rd_addr[31:4] == wr_addr_q[31:4]);
    assign dc_elig = dc_rd_req && !hazard;

    assign ret_data     = mem_ret_data;
    assign mem_rd_type  = rd_type_q;
    assign mem_rd_addr  = rd_addr_q;
    assign mem_wr_type  = wr_type_q;
    assign mem_wr_addr  = wr_addr_q;
    assign mem_wr_wstrb = wr_wstrb_q;
    assign mem_wr_data  = wr_data_q;

    // Read FSM next state, grant selection and owner-steered strobes.
    // Strobes are gated by resetn so nothing leaks while reset is held.
    always_comb begin
        r_next       = r_state;
        grant        = 1'b0;
        grant_dc     = 1'b0;
        mem_rd_req   = 1'b0;
        ic_rd_rdy    = 1'b0;
        dc_rd_rdy    = 1'b0;
        ic_ret_valid = 1'b0;
        ic_ret_last  = 1'b0;
        dc_ret_valid = 1'b0;
        dc_ret_last  = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (ic_rd_req || dc_elig) begin
                    grant  = 1'b1;
                    r_next = R_REQ;
                    if (ic_rd_req && dc_elig)
                        grant_dc = DC_PRIO ? 1'b1 : !last_dc;
                    else
                        grant_dc = dc_elig;
                end
            end
            R_REQ: begin
                mem_rd_req = resetn;
                if (mem_rd_rdy) begin
                    r_next    = R_DATA;
                    ic_rd_rdy = resetn && !owner_dc;
                    dc_rd_rdy = resetn && owner_dc;
                end
            end
            R_DATA: begin
                ic_ret_valid = resetn && !owner_dc && mem_ret_valid;
                ic_ret_last  = resetn && !owner_dc && mem_ret_last;
                dc_ret_valid = resetn && owner_dc && mem_ret_valid;
                dc_ret_last  = resetn && owner_dc && mem_ret_last;
                if (mem_ret_valid && mem_ret_last)
                    r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Read FSM state and round-robin history; reset leaves dcache as the
    // last winner so icache takes the first tie.
    always_ff @(posedge clk_g) begin
        if (!resetn) begin
            r_state <= R_IDLE;
            last_dc <= 1'b1;
        end else begin
            r_state <= r_next;
            if (grant)
                last_dc <= grant_dc;
        end
    end

    // Latch the winning request; held for the whole transaction.
    always_ff @(posedge clk_g) begin
        if (resetn && grant) begin
            owner_dc  <= grant_dc;
            rd_type_q <= grant_dc ? dc_rd_type : ic_rd_type;
            rd_addr_q <= grant_dc ? dc_rd_addr : ic_rd_addr;
        end
    end

    // Write buffer next state; an all-zero strobe write is accepted and dropped.
    always_comb begin
        w_next     = w_state;
        wr_load    = 1'b0;
        mem_wr_req = 1'b0;
        dc_wr_rdy  = !resetn;
        case (w_state)
            W_EMPTY: begin
                dc_wr_rdy = 1'b1;
                if (dc_wr_req && (dc_wr_wstrb != 4'h0)) begin
                    wr_load = 1'b1;
                    w_next  = W_PEND;
                end
            end
            W_PEND: begin
                mem_wr_req = resetn;
                if (mem_wr_rdy)
                    w_next = W_WAIT;
            end
            W_WAIT: begin
                if (mem_wr_done)
                    w_next = W_EMPTY;
            end
            default: w_next = W_EMPTY;
        endcase
    end

    // Write buffer state register.
    always_ff @(posedge clk_g) begin
        if (!resetn)
            w_state <= W_EMPTY;
        else
            w_state <= w_next;
    end

    // Capture the victim line when the buffer takes it.
    always_ff @(posedge clk_g) begin
        if (resetn && wr_load) begin
            wr_type_q  <= dc_wr_type;
            wr_addr_q  <= dc_wr_addr;
            wr_wstrb_q <= dc_wr_wstrb;
            wr_data_q  <= dc_wr_data;
        end
    end

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed bench: per-cycle vector table for the read path plus hand-written
// sequences for write-buffer hazard, dropped writes and mid-read reset.
module tb_cache_axi_arbiter;

    localparam logic [31:0] IC_A = 32'h2000_0000;
    localparam logic [31:0] DC_A = 32'h3000_0010;
    localparam logic [2:0]  IC_T = 3'b100;
    localparam logic [2:0]  DC_T = 3'b010;

    logic         clk_g = 1'b0;
    logic         resetn;
    logic         ic_rd_req, ic_rd_rdy, ic_ret_valid, ic_ret_last;
    logic [2:0]   ic_rd_type;
    logic [31:0]  ic_rd_addr;
    logic         dc_rd_req, dc_rd_rdy, dc_ret_valid, dc_ret_last;
    logic [2:0]   dc_rd_type;
    logic [31:0]  dc_rd_addr;
    logic [31:0]  ret_data;
    logic         dc_wr_req, dc_wr_rdy;
    logic [2:0]   dc_wr_type;
    logic [31:0]  dc_wr_addr;
    logic [3:0]   dc_wr_wstrb;
    logic [127:0] dc_wr_data;
    logic         mem_rd_req, mem_rd_rdy, mem_ret_valid, mem_ret_last;
    logic [2:0]   mem_rd_type;
    logic [31:0]  mem_rd_addr, mem_ret_data;
    logic         mem_wr_req, mem_wr_rdy, mem_wr_done;
    logic [2:0]   mem_wr_type;
    logic [31:0]  mem_wr_addr;
    logic [3:0]   mem_wr_wstrb;
    logic [127:0] mem_wr_data;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk_g = ~clk_g;

    cache_axi_arbiter #(.DC_PRIO(1'b0)) dut (
        .clk_g(clk_g), .resetn(resetn),
        .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr),
        .ic_rd_rdy(ic_rd_rdy), .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last),
        .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr),
        .dc_rd_rdy(dc_rd_rdy), .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last),
        .ret_data(ret_data),
        .dc_wr_req(dc_wr_req), .dc_wr_type(dc_wr_type), .dc_wr_addr(dc_wr_addr),
        .dc_wr_wstrb(dc_wr_wstrb), .dc_wr_data(dc_wr_data), .dc_wr_rdy(dc_wr_rdy),
        .mem_rd_req(mem_rd_req), .mem_rd_type(mem_rd_type), .mem_rd_addr(mem_rd_addr),
        .mem_rd_rdy(mem_rd_rdy), .mem_ret_valid(mem_ret_valid), .mem_ret_last(mem_ret_last),
        .mem_ret_data(mem_ret_data),
        .mem_wr_req(mem_wr_req), .mem_wr_type(mem_wr_type), .mem_wr_addr(mem_wr_addr),
        .mem_wr_wstrb(mem_wr_wstrb), .mem_wr_data(mem_wr_data),
        .mem_wr_rdy(mem_wr_rdy), .mem_wr_done(mem_wr_done)
    );

    // {mem_rd_req, ic_rd_rdy, dc_rd_rdy, ic_ret_valid, ic_ret_last, dc_ret_valid, dc_ret_last}
    logic [6:0] strb;
    assign strb = {mem_rd_req, ic_rd_rdy, dc_rd_rdy, ic_ret_valid, ic_ret_last,
                   dc_ret_valid, dc_ret_last};

    typedef struct {
        logic        ic_req;
        logic        dc_req;
        logic        rrdy;
        logic        rv;
        logic        rl;
        logic [31:0] rdata;
        logic [6:0]  exp_strb;
        logic [31:0] exp_addr;
        logic [2:0]  exp_type;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic ic, logic dc, logic rr, logic v, logic l,
                                logic [31:0] d, logic [6:0] es, logic [31:0] ea,
                                logic [2:0] et);
        vec_t x;
        x.ic_req = ic; x.dc_req = dc; x.rrdy = rr; x.rv = v; x.rl = l;
        x.rdata = d; x.exp_strb = es; x.exp_addr = ea; x.exp_type = et;
        return x;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        resetn = 1'b0;
        ic_rd_req = 0; ic_rd_type = IC_T; ic_rd_addr = IC_A;
        dc_rd_req = 0; dc_rd_type = DC_T; dc_rd_addr = DC_A;
        dc_wr_req = 0; dc_wr_type = 3'b100; dc_wr_addr = 0; dc_wr_wstrb = 0; dc_wr_data = 0;
        mem_rd_rdy = 0; mem_ret_valid = 0; mem_ret_last = 0; mem_ret_data = 0;
        mem_wr_rdy = 0; mem_wr_done = 0;

        // Read-path table: arbitration order, returns, stray returns, round-robin.
        vecs.push_back(mk(1,1,0,0,0,32'h00, 7'b0000000, 32'h0, 3'h0));
        vecs.push_back(mk(1,1,1,0,0,32'h00, 7'b1100000, IC_A, IC_T));
        vecs.push_back(mk(0,1,0,1,0,32'h11, 7'b0001000, 32'h0, 3'h0));
        vecs.push_back(mk(0,1,0,1,0,32'h22, 7'b0001000, 32'h0, 3'h0));
        vecs.push_back(mk(0,1,0,0,0,32'h00, 7'b0000000, 32'h0, 3'h0));
        vecs.push_back(mk(0,1,0,1,0,32'h33, 7'b0001000, 32'h0, 3'h0));
        vecs.push_back(mk(0,1,0,1,1,32'h44, 7'b0001100, 32'h0, 3'h0));
        vecs.push_back(mk(0,1,0,0,0,32'h00, 7'b0000000, 32'h0, 3'h0));
        vecs.push_back(mk(0,1,0,0,0,32'h00, 7'b1000000, DC_A, DC_T));
        vecs.push_back(mk(0,1,1,0,0,32'h00, 7'b1010000, DC_A, DC_T));
        vecs.push_back(mk(0,0,0,1,1,32'hAA, 7'b0000011, 32'h0, 3'h0));
        vecs.push_back(mk(1,1,0,1,1,32'hBB, 7'b0000000, 32'h0, 3'h0));
        vecs.push_back(mk(1,1,1,0,0,32'h00, 7'b1100000, IC_A, IC_T));
        vecs.push_back(mk(0,1,0,1,1,32'h55, 7'b0001100, 32'h0, 3'h0));
        vecs.push_back(mk(1,1,0,0,0,32'h00, 7'b0000000, 32'h0, 3'h0));
        vecs.push_back(mk(1,1,1,0,0,32'h00, 7'b1010000, DC_A, DC_T));
        vecs.push_back(mk(0,0,0,1,1,32'h66, 7'b0000011, 32'h0, 3'h0));
        vecs.push_back(mk(0,0,0,0,0,32'h00, 7'b0000000, 32'h0, 3'h0));

        // Reset state
        @(negedge clk_g); #1;
        @(negedge clk_g); #1;
        chk("reset_strobes", strb, 7'b0);
        chk("reset_wr_rdy", dc_wr_rdy, 1'b1);
        chk("reset_mem_wr_req", mem_wr_req, 1'b0);
        resetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk_g);
            ic_rd_req = vecs[i].ic_req; dc_rd_req = vecs[i].dc_req;
            mem_rd_rdy = vecs[i].rrdy; mem_ret_valid = vecs[i].rv;
            mem_ret_last = vecs[i].rl; mem_ret_data = vecs[i].rdata;
            #1;
            chk($sformatf("vec%0d_strobes", i), strb, vecs[i].exp_strb);
            if (vecs[i].exp_strb[6]) begin
                chk($sformatf("vec%0d_rd_addr", i), mem_rd_addr, vecs[i].exp_addr);
                chk($sformatf("vec%0d_rd_type", i), mem_rd_type, vecs[i].exp_type);
            end
            if (vecs[i].rv)
                chk($sformatf("vec%0d_ret_data", i), ret_data, vecs[i].rdata);
        end

        // Zero-strobe write is swallowed
        @(negedge clk_g);
        mem_ret_valid = 0; mem_ret_last = 0; mem_rd_rdy = 0;
        dc_wr_req = 1; dc_wr_addr = 32'h1000_0040; dc_wr_wstrb = 4'h0;
        dc_wr_data = 128'hDEAD;
        #1 chk("wstrb0_rdy", dc_wr_rdy, 1'b1);
        @(negedge clk_g);
        dc_wr_req = 0; mem_wr_rdy = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("wstrb0_no_wr_req", mem_wr_req, 1'b0);
            chk("wstrb0_rdy_held", dc_wr_rdy, 1'b1);
            @(negedge clk_g);
        end
        mem_wr_rdy = 0;

        // Hazard: buffered write to same line blocks the dcache read
        dc_wr_req = 1; dc_wr_addr = 32'h1000_0040; dc_wr_wstrb = 4'hF;
        dc_wr_data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        #1 chk("haz_wr_accept", dc_wr_rdy, 1'b1);
        @(negedge clk_g);
        dc_wr_req = 0;
        #1;
        chk("haz_wr_req", mem_wr_req, 1'b1);
        chk("haz_wr_addr", mem_wr_addr, 32'h1000_0040);
        chk("haz_wr_data", mem_wr_data, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        chk("haz_wr_wstrb", mem_wr_wstrb, 4'hF);
        chk("haz_wr_busy", dc_wr_rdy, 1'b0);
        @(negedge clk_g);
        mem_wr_rdy = 1;
        @(negedge clk_g);
        mem_wr_rdy = 0;
        dc_rd_req = 1; dc_rd_addr = 32'h1000_004C; mem_rd_rdy = 1;
        #1 chk("haz_wait_wr_req_low", mem_wr_req, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1 chk("haz_blocked", strb, 7'b0);
            @(negedge clk_g);
        end
        mem_wr_done = 1;
        #1 chk("haz_done_cycle", strb, 7'b0);
        @(negedge clk_g);
        mem_wr_done = 0;
        #1;
        chk("haz_after_done", strb, 7'b0);
        chk("haz_buf_empty", dc_wr_rdy, 1'b1);
        @(negedge clk_g); #1;
        chk("haz_granted", strb, 7'b1010000);
        chk("haz_rd_addr", mem_rd_addr, 32'h1000_004C);
        @(negedge clk_g);
        dc_rd_req = 0; mem_rd_rdy = 0;
        mem_ret_valid = 1; mem_ret_last = 1; mem_ret_data = 32'h77;
        #1 chk("haz_ret", strb, 7'b0000011);
        @(negedge clk_g);
        mem_ret_valid = 0; mem_ret_last = 0;

        // Different line: no waiting on the buffered write
        dc_wr_req = 1; dc_wr_addr = 32'h1000_0040; dc_wr_wstrb = 4'h3;
        @(negedge clk_g);
        dc_wr_req = 0; mem_wr_rdy = 1;
        #1 chk("nohaz_wr_wstrb", mem_wr_wstrb, 4'h3);
        @(negedge clk_g);
        mem_wr_rdy = 0;
        dc_rd_req = 1; dc_rd_addr = 32'h1000_0080; mem_rd_rdy = 1;
        #1 chk("nohaz_idle", strb, 7'b0);
        @(negedge clk_g); #1;
        chk("nohaz_granted", strb, 7'b1010000);
        chk("nohaz_rd_addr", mem_rd_addr, 32'h1000_0080);
        chk("nohaz_wr_waiting", dc_wr_rdy, 1'b0);
        @(negedge clk_g);
        dc_rd_req = 0; mem_rd_rdy = 0;
        mem_ret_valid = 1; mem_ret_last = 1; mem_ret_data = 32'h88;
        mem_wr_done = 1;
        #1;
        chk("nohaz_ret", strb, 7'b0000011);
        chk("nohaz_ret_data", ret_data, 32'h88);
        @(negedge clk_g);
        mem_ret_valid = 0; mem_ret_last = 0; mem_wr_done = 0;
        #1 chk("nohaz_wr_done", dc_wr_rdy, 1'b1);

        // Reset in the middle of a read's data phase
        @(negedge clk_g);
        ic_rd_req = 1; ic_rd_addr = IC_A;
        @(negedge clk_g);
        mem_rd_rdy = 1;
        #1 chk("rst_grant", strb, 7'b1100000);
        @(negedge clk_g);
        ic_rd_req = 0; mem_rd_rdy = 0;
        mem_ret_valid = 1; mem_ret_data = 32'h11;
        #1 chk("rst_ret1", strb, 7'b0001000);
        @(negedge clk_g);
        mem_ret_data = 32'h22;
        #1 chk("rst_ret2", strb, 7'b0001000);
        @(negedge clk_g);
        resetn = 0; mem_ret_data = 32'h33;
        #1;
        chk("rst_during", strb, 7'b0);
        chk("rst_during_wr_rdy", dc_wr_rdy, 1'b1);
        @(negedge clk_g);
        resetn = 1; mem_ret_data = 32'h44; mem_ret_last = 1;
        #1 chk("rst_late_ret", strb, 7'b0);
        @(negedge clk_g);
        mem_ret_valid = 0; mem_ret_last = 0;
        #1 chk("rst_quiet", strb, 7'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
